// File: rtl/keypad_scanner_if.sv
// Purpose: bundles the keypad matrix lines and the decoded-key outputs of the scanner.
// Latency: none, wiring only.
// Backpressure: none; key_valid is a one-cycle pulse the consumer must take when it appears.
interface keypad_scanner_if;
    logic [3:0] keypad_row;   // active-low row sense, pulled up externally
    logic [3:0] keypad_col;   // active-low one-cold column drive
    logic [3:0] keypadBuf;    // last accepted key code
    logic       key_valid;    // one-cycle pulse per accepted press
    logic       key_held;     // high from acceptance until release is debounced

    // Scanner side: reads rows, drives columns and key outputs.
    modport master (
        input  keypad_row,
        output keypad_col,
        output keypadBuf,
        output key_valid,
        output key_held
    );

    // Consumer/matrix side.
    modport slave (
        output keypad_row,
        input  keypad_col,
        input  keypadBuf,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// Purpose: 4x4 keypad column scanner with press/release debounce and hex key encoding.
// Latency: key_valid rises on the edge of the DEBOUNCE_CNT-th matching sample of the owning column.
// Backpressure: none; one key_valid pulse per accepted press, rescan waits for a debounced release.
module keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic             clock,
    input  logic             reset_n,
    keypad_scanner_if.master kp
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    // One extra count of headroom so the terminal value itself is representable.
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        RELEASE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_q,   col_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [3:0]    pat_q,   pat_d;
    logic [3:0]    buf_q,   buf_d;
    logic          valid_q, valid_d;
    logic          held_q,  held_d;

    logic       sample;
    logic [3:0] row_low;
    logic       one_low;
    logic       all_high;

    // Row pattern (active-low, one row low) and column index to hex key code.
    function automatic logic [3:0] key_code(input logic [3:0] pat, input logic [1:0] col);
        logic [1:0] row;
        row = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!pat[i]) row = 2'(i);
        end
        key_code = 4'h0;
        case ({row, col})
            4'h0: key_code = 4'h1;
            4'h1: key_code = 4'h2;
            4'h2: key_code = 4'h3;
            4'h3: key_code = 4'hA;
            4'h4: key_code = 4'h4;
            4'h5: key_code = 4'h5;
            4'h6: key_code = 4'h6;
            4'h7: key_code = 4'hB;
            4'h8: key_code = 4'h7;
            4'h9: key_code = 4'h8;
            4'hA: key_code = 4'h9;
            4'hB: key_code = 4'hC;
            4'hC: key_code = 4'hE;
            4'hD: key_code = 4'h0;
            4'hE: key_code = 4'hF;
            4'hF: key_code = 4'hD;
            default: key_code = 4'h0;
        endcase
    endfunction

    assign sample   = (dwell_q == DWELL_LAST);
    assign row_low  = ~kp.keypad_row;
    assign one_low  = (row_low != 4'h0) && ((row_low & (row_low - 4'h1)) == 4'h0);
    assign all_high = (kp.keypad_row == 4'hF);

    assign kp.keypad_col = ~(4'b0001 << col_q);
    assign kp.keypadBuf  = buf_q;
    assign kp.key_valid  = valid_q;
    assign kp.key_held   = held_q;

    // Next-state: dwell timing, column advance and the scan/debounce/release sequence.
    always_comb begin
        state_d = state_q;
        dwell_d = sample ? '0 : dwell_q + DW'(1);
        col_d   = col_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        buf_d   = buf_q;
        valid_d = 1'b0;
        held_d  = held_q;

        case (state_q)
            SCAN: begin
                if (sample) begin
                    if (one_low) begin
                        pat_d = kp.keypad_row;
                        if (DEBOUNCE_CNT == 1) begin
                            buf_d   = key_code(kp.keypad_row, col_q);
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = RELEASE;
                        end else begin
                            cnt_d   = CW'(1);
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        // Idle or ghosted multi-key: keep rotating.
                        col_d = col_q + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (sample) begin
                    if (kp.keypad_row == pat_q) begin
                        if ((cnt_q + CW'(1)) == CNT_LAST) begin
                            buf_d   = key_code(pat_q, col_q);
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = RELEASE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_d   = '0;
                        col_d   = col_q + 2'd1;
                        state_d = SCAN;
                    end
                end
            end
            RELEASE: begin
                if (sample) begin
                    // Any low row, including a second key, restarts the release count.
                    if (all_high) begin
                        if ((cnt_q + CW'(1)) == CNT_LAST) begin
                            held_d  = 1'b0;
                            cnt_d   = '0;
                            col_d   = col_q + 2'd1;
                            state_d = SCAN;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset forces idle scan on column 0 with outputs cleared.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SCAN;
            dwell_q <= '0;
            col_q   <= 2'd0;
            cnt_q   <= '0;
            pat_q   <= 4'hF;
            buf_q   <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            buf_q   <= buf_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Purpose: self-checking bench for keypad_scanner using a simulated key matrix and a sample-level model.
// Latency: model predicts every output on every clock edge.
// Backpressure: not applicable.
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DB       = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    keypad_scanner_if kp_if ();

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DB)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .kp      (kp_if)
    );

    // Physical matrix: bit r*4+c set means the key at row r, column c is pressed.
    logic [15:0] pressed = '0;
    logic [3:0]  phys_row;
    always_comb begin
        phys_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kp_if.keypad_col[c]) phys_row[r] = 1'b0;
    end
    assign kp_if.keypad_row = phys_row;

    int n_checks = 0;
    int n_pass   = 0;
    int dut_pulses = 0;

    // Reference model, evaluated once per sample window.
    string      keymap = "123A456B789CE0FD";
    int         m_tick, m_col, m_cand_row, m_run, m_pulses;
    bit         m_locked, m_valid;
    logic [3:0] m_buf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [3:0] key_of(input int r, input int c);
        byte unsigned ch;
        ch = keymap[r*4+c];
        if (ch >= "A") return 4'(ch - "A" + 10);
        return 4'(ch - "0");
    endfunction

    task automatic model_reset();
        m_tick = 0; m_col = 0; m_cand_row = -1; m_run = 0;
        m_locked = 0; m_valid = 0; m_buf = 4'h0;
    endtask

    task automatic model_accept();
        m_buf = key_of(m_cand_row, m_col);
        m_valid = 1; m_locked = 1; m_run = 0; m_cand_row = -1;
        m_pulses++;
    endtask

    // Advances the model across one clock edge, using the rows the model's own column would see.
    task automatic model_step();
        int lows, lowr;
        bit smp;
        lows = 0; lowr = -1;
        for (int r = 0; r < 4; r++)
            if (pressed[r*4+m_col]) begin lows++; lowr = r; end
        smp = (m_tick == SCAN_DIV - 1);
        m_tick = smp ? 0 : m_tick + 1;
        m_valid = 0;
        if (smp) begin
            if (m_locked) begin
                m_run = (lows == 0) ? m_run + 1 : 0;
                if (m_run == DB) begin m_locked = 0; m_run = 0; m_col = (m_col + 1) % 4; end
            end else if (m_cand_row >= 0) begin
                if (lows == 1 && lowr == m_cand_row) begin
                    m_run++;
                    if (m_run == DB) model_accept();
                end else begin
                    m_cand_row = -1; m_run = 0; m_col = (m_col + 1) % 4;
                end
            end else if (lows == 1) begin
                m_cand_row = lowr; m_run = 1;
                if (m_run == DB) model_accept();
            end else begin
                m_col = (m_col + 1) % 4;
            end
        end
    endtask

    task automatic tick();
        logic [3:0] ecol;
        model_step();
        @(posedge clock);
        #1;
        ecol = 4'hF;
        ecol[m_col] = 1'b0;
        check_eq("keypad_col", kp_if.keypad_col, ecol);
        check_eq("key_valid", kp_if.key_valid, m_valid);
        check_eq("key_held", kp_if.key_held, m_locked);
        check_eq("keypadBuf", kp_if.keypadBuf, m_buf);
        if (kp_if.key_valid) dut_pulses++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_eq("rst_col", kp_if.keypad_col, 4'b1110);
        check_eq("rst_buf", kp_if.keypadBuf, 4'h0);
        check_eq("rst_valid", kp_if.key_valid, 1'b0);
        check_eq("rst_held", kp_if.key_held, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_cand(input string tag);
        int n;
        n = 0;
        while (m_cand_row < 0 && n < 40) begin tick(); n++; end
        check_eq(tag, (m_cand_row >= 0), 1'b1);
    endtask

    initial begin
        int p0, k1, k2;
        m_pulses = 0;
        model_reset();
        #2;
        do_reset();

        // Idle rotation.
        p0 = dut_pulses;
        repeat (40) tick();
        check_eq("idle_pulses", dut_pulses - p0, 0);

        // Key '5' held for 100 clocks.
        p0 = dut_pulses;
        pressed[5] = 1'b1;
        repeat (100) tick();
        pressed = '0;
        repeat (40) tick();
        check_eq("k5_pulses", dut_pulses - p0, 1);
        check_eq("k5_buf", kp_if.keypadBuf, 4'h5);
        check_eq("k5_released", kp_if.key_held, 1'b0);

        // '5' with a one-sample glitch, then a stable retry.
        p0 = dut_pulses;
        pressed[5] = 1'b1;
        wait_cand("glitch_detect");
        pressed = '0;
        repeat (SCAN_DIV) tick();
        check_eq("glitch_pulses", dut_pulses - p0, 0);
        pressed[5] = 1'b1;
        repeat (60) tick();
        pressed = '0;
        repeat (40) tick();
        check_eq("retry_pulses", dut_pulses - p0, 1);
        check_eq("retry_buf", kp_if.keypadBuf, 4'h5);

        // Ghost: rows 0 and 2 on column 0.
        p0 = dut_pulses;
        pressed[0] = 1'b1;
        pressed[8] = 1'b1;
        repeat (60) tick();
        pressed = '0;
        repeat (20) tick();
        check_eq("ghost_pulses", dut_pulses - p0, 0);

        // '#' then '0' pressed while '#' still held.
        p0 = dut_pulses;
        pressed[14] = 1'b1;
        repeat (60) tick();
        pressed[13] = 1'b1;
        repeat (40) tick();
        check_eq("hash_pulses", dut_pulses - p0, 1);
        check_eq("hash_buf", kp_if.keypadBuf, 4'hF);
        pressed[14] = 1'b0;
        repeat (80) tick();
        check_eq("zero_pulses", dut_pulses - p0, 2);
        check_eq("zero_buf", kp_if.keypadBuf, 4'h0);
        pressed = '0;
        repeat (40) tick();

        // Reset during debounce of 'A'; 'A' stays down and must be re-debounced.
        p0 = dut_pulses;
        pressed[3] = 1'b1;
        wait_cand("a_detect");
        tick();
        do_reset();
        check_eq("a_reset_pulses", dut_pulses - p0, 0);
        repeat (80) tick();
        check_eq("a_pulses", dut_pulses - p0, 1);
        check_eq("a_buf", kp_if.keypadBuf, 4'hA);
        pressed = '0;
        repeat (40) tick();

        // Random presses, occasionally with a second key rolled in.
        for (int i = 0; i < 12; i++) begin
            k1 = $urandom_range(0, 15);
            pressed[k1] = 1'b1;
            repeat ($urandom_range(20, 60)) tick();
            if ($urandom_range(0, 1) == 1) begin
                k2 = $urandom_range(0, 15);
                pressed[k2] = 1'b1;
            end
            repeat ($urandom_range(0, 60)) tick();
            pressed = '0;
            repeat ($urandom_range(30, 60)) tick();
        end

        check_eq("total_pulses", dut_pulses, m_pulses);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
